// File: rtl/bus_mem_if.sv
// bus_mem_if: instruction and data bus bundle between the hart and bus_mem.
//   Instruction bus: b_addr_i, b_rd_i (hart out), b_data_i, b_dv_i (memory out).
//   Data bus:        b_addr, b_rd, b_wr, b_data_out (hart out), b_data_in, b_dv (memory out).
//   Modports: master (hart side), slave (memory side).
//   Line widths default to the RV6_IMEM_LINE / RV6_DMEM_LINE macros when those are defined.

`ifndef RV6_IMEM_LINE
`define RV6_IMEM_LINE 512
`endif
`ifndef RV6_DMEM_LINE
`define RV6_DMEM_LINE `RV6_IMEM_LINE
`endif

interface bus_mem_if #(
  parameter int unsigned IMEM_LINE = `RV6_IMEM_LINE,
  parameter int unsigned DMEM_LINE = `RV6_DMEM_LINE
);
  logic [63:0]          b_addr_i;
  logic [IMEM_LINE-1:0] b_data_i;
  logic                 b_rd_i;
  logic                 b_dv_i;
  logic [63:0]          b_addr;
  logic [DMEM_LINE-1:0] b_data_in;
  logic                 b_rd;
  logic                 b_dv;
  logic [DMEM_LINE-1:0] b_data_out;
  logic                 b_wr;

  modport master (
    output b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr,
    input  b_data_i, b_dv_i, b_data_in, b_dv
  );

  modport slave (
    input  b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr,
    output b_data_i, b_dv_i, b_data_in, b_dv
  );
endinterface

// File: rtl/bus_mem.sv
// bus_mem: single-port line memory serving the hart's instruction and data buses.
//   One transaction in flight; each is acknowledged by a one-cycle dv pulse on the winning
//   port LATENCY+1 cycles after the request is sampled.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bus_mem_if.slave (instruction fetch port + data read/write port)
// Configuration macro:
//   RV6_BUS_RR_EN - round-robin arbitration between the ports; undefined gives fixed
//                   priority with the data bus winning.

`ifndef RV6_IMEM_LINE
`define RV6_IMEM_LINE 512
`endif
`ifndef RV6_DMEM_LINE
`define RV6_DMEM_LINE `RV6_IMEM_LINE
`endif

module bus_mem #(
  parameter int unsigned IMEM_LINE  = `RV6_IMEM_LINE,
  parameter int unsigned DMEM_LINE  = `RV6_DMEM_LINE,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 4
) (
  input  logic     clk,
  input  logic     rst,
  bus_mem_if.slave bus
);
  localparam int unsigned Offs    = $clog2(IMEM_LINE / 8);
  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [3:0]            r_cnt;
  logic                  r_port;   // 1: data bus owns the transaction
  logic                  r_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DMEM_LINE-1:0]  r_wdata;
  logic [IMEM_LINE-1:0]  r_data_i;
  logic [DMEM_LINE-1:0]  r_data_in;
  logic [DMEM_LINE-1:0]  r_mem [Depth];

  logic                  w_req_d;
  logic                  w_req_i;
  logic                  w_req;
  logic                  w_grant_d;
  logic                  w_fire;
  logic [DEPTH_LOG2-1:0] w_idx_d;
  logic [DEPTH_LOG2-1:0] w_idx_i;
  logic                  w_unused_addr;

  assign w_req_d = bus.b_wr | bus.b_rd;
  assign w_req_i = bus.b_rd_i;
  assign w_req   = w_req_d | w_req_i;
  assign w_idx_d = bus.b_addr[DEPTH_LOG2+Offs-1:Offs];
  assign w_idx_i = bus.b_addr_i[DEPTH_LOG2+Offs-1:Offs];
  // Last BUSY edge: the array access happens here.
  assign w_fire  = (r_state == StBusy) && (r_cnt == 4'd0);

  // Offset and wrap bits of the addresses are deliberately ignored.
  assign w_unused_addr = ^{bus.b_addr_i[63:DEPTH_LOG2+Offs], bus.b_addr_i[Offs-1:0],
                           bus.b_addr[63:DEPTH_LOG2+Offs], bus.b_addr[Offs-1:0]};

`ifdef RV6_BUS_RR_EN
  logic r_rr;  // 1: data bus preferred on the next conflict

  assign w_grant_d = w_req_d & (~w_req_i | r_rr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= 1'b1;
    end else if ((r_state == StIdle) && w_req) begin
      r_rr <= ~w_grant_d;
    end
  end
`else
  assign w_grant_d = w_req_d;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_req) w_state_next = StBusy;
      StBusy:  if (r_cnt == 4'd0) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: dv is decoded from registered state only.
  always_comb begin
    bus.b_dv   = 1'b0;
    bus.b_dv_i = 1'b0;
    if (r_state == StDone) begin
      bus.b_dv   = r_port;
      bus.b_dv_i = ~r_port;
    end
  end

  assign bus.b_data_i  = r_data_i;
  assign bus.b_data_in = r_data_in;

  // Transaction latch, latency counter and read data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_port    <= 1'b1;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_data_i  <= '0;
      r_data_in <= '0;
    end else begin
      if ((r_state == StIdle) && w_req) begin
        r_port <= w_grant_d;
        r_wr   <= w_grant_d & bus.b_wr;
        r_idx  <= w_grant_d ? w_idx_d : w_idx_i;
        r_cnt  <= CntLoad;
        if (w_grant_d && bus.b_wr) begin
          r_wdata <= bus.b_data_out;
        end
      end else if ((r_state == StBusy) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_wr) begin
        if (r_port) begin
          r_data_in <= r_mem[r_idx];
        end else begin
          r_data_i <= r_mem[r_idx];
        end
      end
    end
  end

  // Array is never reset; reset forces StIdle so an interrupted write is dropped.
  always_ff @(posedge clk) begin
    if (w_fire && r_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end
endmodule

// File: tb/tb_bus_mem.sv
module tb_bus_mem;
  localparam int unsigned LW    = 512;
  localparam int unsigned DL2   = 12;
  localparam int unsigned LAT   = 4;
  localparam int unsigned OFFS  = 6;
  localparam int unsigned DEPTH = 1 << DL2;

  logic clk;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;
  bit   chk_en = 0;

  bus_mem_if #(.IMEM_LINE(LW), .DMEM_LINE(LW)) bus ();

  bus_mem #(
    .IMEM_LINE (LW),
    .DMEM_LINE (LW),
    .DEPTH_LOG2(DL2),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a request seen while the memory is free completes LAT edges
  // later; the memory is free again two edges after completion.
  logic [LW-1:0] mmem [int];
  bit            pend;
  longint        cyc, done_at, free_at;
  bit            p_data_port, p_wr;
  int            p_idx;
  logic [LW-1:0] p_data;
  bit            ptr;
  logic          m_dv, m_dv_i;
  logic [LW-1:0] m_dd, m_di;
  bit            m_dd_k, m_di_k;

  function automatic int line_of(input logic [63:0] a);
    logic [63:0] t;
    t = (a >> OFFS) % DEPTH;
    return int'(t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0; free_at = 0; cyc = 0; ptr = 1;
      m_dv = 0; m_dv_i = 0; m_dd = '0; m_di = '0; m_dd_k = 1; m_di_k = 1;
    end else begin
      bit dreq, ireq, gd;
      cyc++;
      m_dv = 0;
      m_dv_i = 0;
      if (pend && cyc == done_at) begin
        pend = 0;
        if (p_wr) mmem[p_idx] = p_data;
        else if (p_data_port) begin
          m_dd_k = mmem.exists(p_idx);
          if (m_dd_k) m_dd = mmem[p_idx];
        end else begin
          m_di_k = mmem.exists(p_idx);
          if (m_di_k) m_di = mmem[p_idx];
        end
        if (p_data_port) m_dv = 1; else m_dv_i = 1;
      end
      dreq = bus.b_wr | bus.b_rd;
      ireq = bus.b_rd_i;
      if (!pend && cyc >= free_at && (dreq || ireq)) begin
`ifdef RV6_BUS_RR_EN
        gd  = dreq && (!ireq || ptr);
        ptr = !gd;
`else
        gd  = dreq;
`endif
        p_data_port = gd;
        p_wr        = gd && bus.b_wr;
        p_idx       = line_of(gd ? bus.b_addr : bus.b_addr_i);
        p_data      = bus.b_data_out;
        pend        = 1;
        done_at     = cyc + LAT;
        free_at     = cyc + LAT + 2;
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dv", LW'(bus.b_dv), LW'(m_dv));
      chk("dv_i", LW'(bus.b_dv_i), LW'(m_dv_i));
      if (m_dd_k) chk("data_in", bus.b_data_in, m_dd);
      if (m_di_k) chk("data_i", bus.b_data_i, m_di);
    end
  end

  task automatic xact(input bit ins, input bit wr, input bit rd, input logic [63:0] addr,
                      input logic [LW-1:0] wd, output int lat);
    @(negedge clk);
    if (ins) begin
      bus.b_addr_i = addr;
      bus.b_rd_i   = 1'b1;
    end else begin
      bus.b_addr     = addr;
      bus.b_data_out = wd;
      bus.b_wr       = wr;
      bus.b_rd       = rd;
    end
    @(posedge clk);
    #1;
    bus.b_rd_i = 1'b0;
    bus.b_wr   = 1'b0;
    bus.b_rd   = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ins ? bus.b_dv_i : bus.b_dv) && lat < 40);
  endtask

  logic [LW-1:0] pat_a5, pat_11, pat_22, pat_33, pat_44;
  int            lat;

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_11 = {64{8'h11}};
    pat_22 = {64{8'h22}};
    pat_33 = {64{8'h33}};
    pat_44 = {64{8'h44}};
    rst = 1'b0;
    bus.b_addr_i = '0; bus.b_rd_i = 1'b0;
    bus.b_addr = '0; bus.b_rd = 1'b0; bus.b_wr = 1'b0; bus.b_data_out = '0;
    #2 rst = 1'b1;
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_dv", LW'(bus.b_dv), '0);
    chk("rst_dv_i", LW'(bus.b_dv_i), '0);
    chk("rst_data_in", bus.b_data_in, '0);
    chk("rst_data_i", bus.b_data_i, '0);
    rst = 1'b0;

    // Write then read line 0x40.
    xact(0, 1, 0, 64'h40, pat_a5, lat);
    chk("wr_lat", LW'(lat), LW'(LAT + 1));
    xact(0, 0, 1, 64'h40, '0, lat);
    chk("rd_lat", LW'(lat), LW'(LAT + 1));
    chk("rd_data", bus.b_data_in, pat_a5);

    // Instruction fetch of the same line.
    xact(1, 0, 0, 64'h40, '0, lat);
    chk("if_lat", LW'(lat), LW'(LAT + 1));
    chk("if_data", bus.b_data_i, pat_a5);
    chk("if_no_dv", LW'(bus.b_dv), '0);

    // Conflict: both ports request together and hold until served.
    begin
      int first = -1;
      bit got_d = 0, got_i = 0;
      @(negedge clk);
      bus.b_addr = 64'h40; bus.b_rd = 1'b1;
      bus.b_addr_i = 64'h40; bus.b_rd_i = 1'b1;
      for (int k = 0; k < 60 && !(got_d && got_i); k++) begin
        @(negedge clk);
        if (bus.b_dv) begin
          got_d = 1; if (first < 0) first = 1; bus.b_rd = 1'b0;
        end
        if (bus.b_dv_i) begin
          got_i = 1; if (first < 0) first = 0; bus.b_rd_i = 1'b0;
        end
      end
      bus.b_rd = 1'b0; bus.b_rd_i = 1'b0;
      chk("conf_both_done", LW'({got_d, got_i}), LW'(2'b11));
`ifndef RV6_BUS_RR_EN
      chk("conf_data_first", LW'(first), LW'(1));
`endif
    end
`ifdef RV6_BUS_RR_EN
    begin
      int seq[4];
      int n = 0;
      @(negedge clk);
      bus.b_addr = 64'h40; bus.b_rd = 1'b1;
      bus.b_addr_i = 64'h40; bus.b_rd_i = 1'b1;
      for (int k = 0; k < 80 && n < 4; k++) begin
        @(negedge clk);
        if (bus.b_dv) begin seq[n] = 1; n++; end
        else if (bus.b_dv_i) begin seq[n] = 0; n++; end
      end
      bus.b_rd = 1'b0; bus.b_rd_i = 1'b0;
      chk("rr_count", LW'(n), LW'(4));
      for (int k = 1; k < 4; k++) chk("rr_alternate", LW'(seq[k] != seq[k-1]), LW'(1));
    end
`endif

    // Address wrap: upper bits ignored.
    xact(0, 1, 0, (64'd1 << (DL2 + OFFS)) + 64'h40, pat_11, lat);
    xact(0, 0, 1, 64'h40, '0, lat);
    chk("wrap_data", bus.b_data_in, pat_11);

    // Write and read together: write wins, read data register untouched.
    xact(0, 1, 1, 64'h40, pat_22, lat);
    chk("wrrd_lat", LW'(lat), LW'(LAT + 1));
    chk("wrrd_keep", bus.b_data_in, pat_11);
    xact(0, 0, 1, 64'h40, '0, lat);
    chk("wrrd_data", bus.b_data_in, pat_22);

    // Reset during a write drops it.
    xact(0, 1, 0, 64'h80, pat_44, lat);
    begin
      bit saw = 0;
      @(negedge clk);
      bus.b_addr = 64'h80; bus.b_data_out = pat_33; bus.b_wr = 1'b1;
      @(posedge clk);
      #1 bus.b_wr = 1'b0;
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_dv", LW'(bus.b_dv), '0);
      chk("arst_data_in", bus.b_data_in, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
        @(negedge clk);
        if (bus.b_dv || bus.b_dv_i) saw = 1;
      end
      chk("arst_no_dv", LW'(saw), '0);
    end
    xact(0, 0, 1, 64'h80, '0, lat);
    chk("arst_keep", bus.b_data_in, pat_44);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
